// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM state encoding,
// owner codes and the line/address width defaults used by both cache controllers.
package mem_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 28;
    localparam int LINE_WIDTH_DEF = 256;

    // State encoding doubles as the owner code seen on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SERVE_D = 2'b01,
        ST_SERVE_I = 2'b10
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_D    = 2'b01;
    localparam logic [1:0] OWNER_I    = 2'b10;

endpackage

// File: rtl/mem_arb_priority.sv
// Grant decision for the shared memory port: the data side wins by default,
// but an instruction fill that has watched STARVE_LIMIT consecutive data
// grants go by is forced through on the next arbitration.
module mem_arb_priority #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_valid,
    input  logic i_valid,
    input  logic arb_en,
    output logic grant_d,
    output logic grant_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak;
    logic       starving;

    assign starving = (streak >= LIMIT);
    assign grant_i  = arb_en & i_valid & (starving | ~d_valid);
    assign grant_d  = arb_en & d_valid & ~grant_i;

    // Count data grants that overtook a waiting fill; saturate at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 4'd0;
        end else if (grant_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            streak <= 4'd0;
        end else if (grant_d) begin
            if (i_valid) begin
                streak <= (streak == 4'hF) ? streak : streak + 4'd1;
            end else begin
                streak <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the line-wide main-memory port between the D-cache and I-cache
// controllers. One owner per transaction; the request is latched at grant and
// held until memory completes, and completion is steered back to the owner only.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int LINE_WIDTH   = LINE_WIDTH_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wr,
    input  logic                  d_rw,
    input  logic                  d_valid,
    output logic [LINE_WIDTH-1:0] d_rd,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_valid,
    output logic [LINE_WIDTH-1:0] i_rd,
    output logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wr,
    output logic                  mem_rw,
    output logic                  mem_valid,
    input  logic [LINE_WIDTH-1:0] mem_rd,
    input  logic                  mem_ready,
    output logic [1:0]            owner
);

    arb_state_e state_q, state_d;
    logic       grant_d, grant_i;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_valid (d_valid),
        .i_valid (i_valid),
        .arb_en  (state_q == ST_IDLE),
        .grant_d (grant_d),
        .grant_i (grant_i)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on a grant, return to IDLE on memory completion.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d)      state_d = ST_SERVE_D;
                else if (grant_i) state_d = ST_SERVE_I;
            end
            ST_SERVE_D, ST_SERVE_I: begin
                if (mem_ready)    state_d = ST_IDLE;
            end
            default:              state_d = ST_IDLE;
        endcase
    end

    // Request latch: capture the winner at grant and hold it for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide datapath registers are reset too because memory
            // observes them directly and must never see X after reset.
            mem_addr <= '0;
            mem_wr   <= '0;
            mem_rw   <= 1'b0;
        end else if (grant_d) begin
            mem_addr <= d_addr;
            mem_wr   <= d_wr;
            mem_rw   <= d_rw;
        end else if (grant_i) begin
            mem_addr <= i_addr;
            mem_wr   <= '0;
            mem_rw   <= 1'b0;
        end
    end

    // Request valid and owner come straight from the state register, so the
    // memory side never sees a combinational path from the requesters' valids.
    assign mem_valid = (state_q != ST_IDLE);
    assign owner     = state_q;

    // Return steering: completion reaches only the owner, and only if it is still asking.
    always_comb begin
        d_ready = 1'b0;
        i_ready = 1'b0;
        d_rd    = '0;
        i_rd    = '0;
        if (mem_ready) begin
            if (state_q == ST_SERVE_D && d_valid) begin
                d_ready = 1'b1;
                d_rd    = mem_rd;
            end
            if (state_q == ST_SERVE_I && i_valid) begin
                i_ready = 1'b1;
                i_rd    = mem_rd;
            end
        end
    end

endmodule
